bip_control_unit: RTL and testbench
===================================

Name: bip_control_unit

Overview:
- Sequential control unit for the BIP accumulator processor; successor to the combinational opcode decoder.
- Owns the program counter and a run/halt FSM with a start handshake.
- Decodes a widened opcode set: the original 8 opcodes plus logic ops and branches.
- Issues per-instruction datapath strobes in a fixed 2-cycle fetch/execute schedule; sits between program memory, data RAM and the ALU/accumulator datapath.

Parameters:
- NB_OPCODE, 5, opcode field width (instruction MSBs).
- NB_OPERAND, 11, operand field width (instruction LSBs); must be >= NB_ADDR.
- NB_ADDR, 11, program counter / program memory address width.
- NB_ALUOP, 2, ALU operation select width.
- NB_CYCLES, 32, cycle counter width (optional feature only).

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle run request.
- i_instruction  in  NB_OPCODE+NB_OPERAND  program memory read data (sync RAM, 1-cycle latency).
- i_acc_zero  in  1  accumulator == 0 flag from datapath.
- o_pc  out  NB_ADDR  program memory address.
- o_operand  out  NB_OPERAND  instruction operand (RAM address / immediate).
- o_selA  out  2  accumulator input mux: 00 RAM, 01 immediate, 10 ALU.
- o_selB  out  1  ALU B mux: 0 RAM, 1 immediate.
- o_wr_Acc  out  1  accumulator write enable.
- o_op  out  NB_ALUOP  ALU op: 00 add, 01 sub, 10 and, 11 xor.
- o_wr_Ram  out  1  data RAM write.
- o_rd_Ram  out  1  data RAM read.
- o_busy  out  1  high in FETCH/EXEC.
- o_halted  out  1  high in HALTED.
- o_illegal  out  1  sticky: halted on an undefined opcode.
- o_cycle_count  out  NB_CYCLES  busy-cycle count (optional feature).

Behaviour:
- FSM states: IDLE, FETCH, EXEC, HALTED.
- Reset (async): state IDLE, PC 0, o_illegal 0, counter 0. Every output is 0.
- IDLE: i_start=1 -> FETCH.
- FETCH: memory samples o_pc. Next state is always EXEC. All strobes 0.
- EXEC: i_instruction is valid. Strobes decode combinationally from it, gated by state == EXEC. Strobes are 0 in every other state.
- o_operand = i_instruction[NB_OPERAND-1:0] in every state; consumers use it only in EXEC.
- Opcode map:
  - 00000 HLT: all strobes 0. -> HALTED, PC unchanged.
  - 00001–00111: identical strobes to the original decoder (STO, LD, LDI, ADD, ADDI, SUB, SUBI). op 00 for add, 01 for sub.
  - 01000 AND var: selA 10, selB 0, wr_Acc 1, rd_Ram 1, op 10.
  - 01001 AND imm: selA 10, selB 1, wr_Acc 1, op 10.
  - 01010 XOR var: selA 10, selB 0, wr_Acc 1, rd_Ram 1, op 11.
  - 01011 XOR imm: selA 10, selB 1, wr_Acc 1, op 11.
  - 01100 JMP: PC <= operand[NB_ADDR-1:0]. No strobes.
  - 01101 BEQ: taken if i_acc_zero=1.
  - 01110 BNE: taken if i_acc_zero=0.
  - Any other opcode: strobes 0, o_illegal <= 1, -> HALTED, PC unchanged.
- i_acc_zero is sampled in EXEC and reflects the accumulator before the current instruction's write.
- PC update at end of EXEC (non-halting): taken branch or JMP -> target, else PC+1. PC+1 wraps from 2^NB_ADDR-1 to 0. Then -> FETCH.
- Throughput: one instruction per 2 cycles. First strobes appear 2 cycles after the i_start cycle.
- HALTED: i_start=1 -> PC 0, o_illegal cleared, -> FETCH (restart).
- i_start during FETCH/EXEC is ignored.
- Reset asserted mid-instruction aborts immediately: strobes drop asynchronously and no RAM write completes.

Optional Feature:
- Macro: BIP_CYCLE_COUNT_EN.
- Defined:
  - o_cycle_count increments each cycle with o_busy=1 and saturates at all-ones.
  - Clears on reset and on a start from IDLE or HALTED.
  - Holds while HALTED or IDLE.
- Undefined: o_cycle_count tied to 0; no counter flops.

Decomposition:
- Package bip_pkg holds:
  - opcode localparams (OP_HLT … OP_BNE);
  - selA encodings (SELA_RAM/IMM/ALU);
  - ALU op codes (ALU_ADD/SUB/AND/XOR);
  - FSM state encoding.
- One sub-module, bip_opcode_decode: pure combinational opcode -> strobe bundle plus is_branch, is_halt and is_illegal flags. The top holds the FSM, PC and counter.

Test Plan:
- Reset then i_start; program LDI 5, ADDI 3, STO 7, HLT -> EXEC strobes match the map; wr_Ram=1 with operand 7 in the third EXEC; o_halted=1 with PC=3; o_busy fell after 8 busy cycles; o_cycle_count=8 when enabled.
- JMP 0x7FF then next instruction -> o_pc=0x7FF; a following non-branch wraps PC to 0.
- BEQ 20 with i_acc_zero=1 -> PC=20. BNE 20 with i_acc_zero=1 -> PC advances by 1.
- Opcode 11111 -> strobes 0, o_illegal=1, o_halted=1; then i_start -> o_illegal=0, PC=0, FETCH.
- i_reset pulsed during EXEC of STO -> o_wr_Ram drops in the same cycle; PC=0, state IDLE, all outputs 0.
- i_start pulses during FETCH/EXEC -> no effect on PC or sequence.

Source files
------------

// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip_pkg
// Description : Shared opcode, mux-select, ALU-op and FSM encodings for the
//               BIP control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

   localparam logic [4:0] OP_HLT  = 5'b00000;
   localparam logic [4:0] OP_STO  = 5'b00001;
   localparam logic [4:0] OP_LD   = 5'b00010;
   localparam logic [4:0] OP_LDI  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SUBI = 5'b00111;
   localparam logic [4:0] OP_AND  = 5'b01000;
   localparam logic [4:0] OP_ANDI = 5'b01001;
   localparam logic [4:0] OP_XOR  = 5'b01010;
   localparam logic [4:0] OP_XORI = 5'b01011;
   localparam logic [4:0] OP_JMP  = 5'b01100;
   localparam logic [4:0] OP_BEQ  = 5'b01101;
   localparam logic [4:0] OP_BNE  = 5'b01110;

   localparam logic [1:0] SELA_RAM = 2'b00;
   localparam logic [1:0] SELA_IMM = 2'b01;
   localparam logic [1:0] SELA_ALU = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_XOR = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   typedef struct packed {
      logic [1:0] sel_a;
      logic       sel_b;
      logic       wr_acc;
      logic [1:0] op;
      logic       wr_ram;
      logic       rd_ram;
   } strobes_t;

   localparam strobes_t STROBES_NONE = '0;

endpackage
`default_nettype wire

// File: rtl/bip_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module      : bip_opcode_decode
// Description : Combinational opcode to datapath-strobe decoder with branch,
//               halt and illegal-opcode classification.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_opcode_decode
   import bip_pkg::*;
#(
   parameter int NB_OPCODE = 5
) (
   input  logic [NB_OPCODE-1:0] i_opcode,
   output strobes_t             o_strobes,
   output logic                 o_is_branch,
   output logic                 o_br_if_zero,
   output logic                 o_br_if_nonzero,
   output logic                 o_is_halt,
   output logic                 o_is_illegal
);

   always_comb begin
      o_strobes       = STROBES_NONE;
      o_is_branch     = 1'b0;
      o_br_if_zero    = 1'b0;
      o_br_if_nonzero = 1'b0;
      o_is_halt       = 1'b0;
      o_is_illegal    = 1'b0;
      case (i_opcode)
         NB_OPCODE'(OP_HLT): o_is_halt = 1'b1;
         NB_OPCODE'(OP_STO): o_strobes.wr_ram = 1'b1;
         NB_OPCODE'(OP_LD): begin
            o_strobes.sel_a  = SELA_RAM;
            o_strobes.wr_acc = 1'b1;
            o_strobes.rd_ram = 1'b1;
         end
         NB_OPCODE'(OP_LDI): begin
            o_strobes.sel_a  = SELA_IMM;
            o_strobes.wr_acc = 1'b1;
         end
         NB_OPCODE'(OP_ADD), NB_OPCODE'(OP_SUB),
         NB_OPCODE'(OP_AND), NB_OPCODE'(OP_XOR): begin
            o_strobes.sel_a  = SELA_ALU;
            o_strobes.sel_b  = 1'b0;
            o_strobes.wr_acc = 1'b1;
            o_strobes.rd_ram = 1'b1;
         end
         NB_OPCODE'(OP_ADDI), NB_OPCODE'(OP_SUBI),
         NB_OPCODE'(OP_ANDI), NB_OPCODE'(OP_XORI): begin
            o_strobes.sel_a  = SELA_ALU;
            o_strobes.sel_b  = 1'b1;
            o_strobes.wr_acc = 1'b1;
         end
         NB_OPCODE'(OP_JMP): o_is_branch = 1'b1;
         NB_OPCODE'(OP_BEQ): begin
            o_is_branch  = 1'b1;
            o_br_if_zero = 1'b1;
         end
         NB_OPCODE'(OP_BNE): begin
            o_is_branch     = 1'b1;
            o_br_if_nonzero = 1'b1;
         end
         default: o_is_illegal = 1'b1;
      endcase

      // ALU op follows the arithmetic/logic family of the opcode
      case (i_opcode)
         NB_OPCODE'(OP_SUB), NB_OPCODE'(OP_SUBI): o_strobes.op = ALU_SUB;
         NB_OPCODE'(OP_AND), NB_OPCODE'(OP_ANDI): o_strobes.op = ALU_AND;
         NB_OPCODE'(OP_XOR), NB_OPCODE'(OP_XORI): o_strobes.op = ALU_XOR;
         default:                                 o_strobes.op = ALU_ADD;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bip_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : bip_control_unit
// Description : BIP sequential control unit: run/halt FSM, program counter and
//               2-cycle fetch/execute strobe schedule. Optional busy-cycle
//               counter enabled by defining BIP_CYCLE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_control_unit
   import bip_pkg::*;
#(
   parameter int NB_OPCODE  = 5,
   parameter int NB_OPERAND = 11,
   parameter int NB_ADDR    = 11,
   parameter int NB_ALUOP   = 2,
   parameter int NB_CYCLES  = 32
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_start,
   input  logic [NB_OPCODE+NB_OPERAND-1:0] i_instruction,
   input  logic                          i_acc_zero,
   output logic [NB_ADDR-1:0]            o_pc,
   output logic [NB_OPERAND-1:0]         o_operand,
   output logic [1:0]                    o_selA,
   output logic                          o_selB,
   output logic                          o_wr_Acc,
   output logic [NB_ALUOP-1:0]           o_op,
   output logic                          o_wr_Ram,
   output logic                          o_rd_Ram,
   output logic                          o_busy,
   output logic                          o_halted,
   output logic                          o_illegal,
   output logic [NB_CYCLES-1:0]          o_cycle_count
);

   logic [1:0]           r_state;
   logic [1:0]           w_state_next;
   logic [NB_ADDR-1:0]   r_pc;
   logic [NB_ADDR-1:0]   w_pc_next;
   logic                 r_illegal;
   logic                 w_illegal_next;
   logic                 w_count_clear;
   logic                 w_exec;
   logic                 w_busy;
   logic                 w_taken;
   logic [NB_OPCODE-1:0] w_opcode;
   strobes_t             w_dec_strobes;
   strobes_t             w_strobes;
   logic                 w_is_branch;
   logic                 w_br_if_zero;
   logic                 w_br_if_nonzero;
   logic                 w_is_halt;
   logic                 w_is_illegal;

   assign w_opcode  = i_instruction[NB_OPCODE+NB_OPERAND-1 -: NB_OPCODE];
   assign o_operand = i_instruction[NB_OPERAND-1:0];

   bip_opcode_decode #(
      .NB_OPCODE (NB_OPCODE)
   ) u_decode (
      .i_opcode        (w_opcode),
      .o_strobes       (w_dec_strobes),
      .o_is_branch     (w_is_branch),
      .o_br_if_zero    (w_br_if_zero),
      .o_br_if_nonzero (w_br_if_nonzero),
      .o_is_halt       (w_is_halt),
      .o_is_illegal    (w_is_illegal)
   );

   assign w_exec = (r_state == ST_EXEC);
   assign w_busy = (r_state == ST_FETCH) || w_exec;

   // Strobes derive from the state register, so an async reset kills them at once
   assign w_strobes = w_exec ? w_dec_strobes : STROBES_NONE;

   assign w_taken = w_is_branch
                  & ~(w_br_if_zero    & ~i_acc_zero)
                  & ~(w_br_if_nonzero &  i_acc_zero);

   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_illegal_next = r_illegal;
      w_count_clear  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_next  = ST_FETCH;
               w_count_clear = 1'b1;
            end
         end
         ST_FETCH: w_state_next = ST_EXEC;
         ST_EXEC: begin
            if (w_is_illegal) begin
               w_illegal_next = 1'b1;
               w_state_next   = ST_HALTED;
            end else if (w_is_halt) begin
               w_state_next = ST_HALTED;
            end else begin
               w_pc_next    = w_taken ? i_instruction[NB_ADDR-1:0] : r_pc + NB_ADDR'(1);
               w_state_next = ST_FETCH;
            end
         end
         ST_HALTED: begin
            if (i_start) begin
               w_pc_next      = '0;
               w_illegal_next = 1'b0;
               w_state_next   = ST_FETCH;
               w_count_clear  = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_pc      <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_illegal <= w_illegal_next;
      end
   end

`ifdef BIP_CYCLE_COUNT_EN
   logic [NB_CYCLES-1:0] r_cycle_count;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cycle_count <= '0;
      end else if (w_count_clear) begin
         r_cycle_count <= '0;
      end else if (w_busy && (r_cycle_count != '1)) begin
         r_cycle_count <= r_cycle_count + NB_CYCLES'(1);
      end
   end

   assign o_cycle_count = r_cycle_count;
`else
   assign o_cycle_count = '0;
`endif

   assign o_pc      = r_pc;
   assign o_selA    = w_strobes.sel_a;
   assign o_selB    = w_strobes.sel_b;
   assign o_wr_Acc  = w_strobes.wr_acc;
   assign o_op      = NB_ALUOP'(w_strobes.op);
   assign o_wr_Ram  = w_strobes.wr_ram;
   assign o_rd_Ram  = w_strobes.rd_ram;
   assign o_busy    = w_busy;
   assign o_halted  = (r_state == ST_HALTED);
   assign o_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bip_control_unit
// Description : Scoreboard bench for bip_control_unit with a sync program RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_control_unit;

   typedef struct packed {
      logic [10:0] pc;
      logic [10:0] operand;
      logic [7:0]  strb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        acc_zero;
   logic [15:0] instr;
   logic [10:0] o_pc;
   logic [10:0] o_operand;
   logic [1:0]  o_selA;
   logic        o_selB;
   logic        o_wr_Acc;
   logic [1:0]  o_op;
   logic        o_wr_Ram;
   logic        o_rd_Ram;
   logic        o_busy;
   logic        o_halted;
   logic        o_illegal;
   logic [31:0] o_cycle_count;

   logic [15:0] mem [0:2047];
   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          phase = 0;

   always #5 clk = ~clk;

   always @(posedge clk) instr <= mem[o_pc];

   bip_control_unit dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_start       (start),
      .i_instruction (instr),
      .i_acc_zero    (acc_zero),
      .o_pc          (o_pc),
      .o_operand     (o_operand),
      .o_selA        (o_selA),
      .o_selB        (o_selB),
      .o_wr_Acc      (o_wr_Acc),
      .o_op          (o_op),
      .o_wr_Ram      (o_wr_Ram),
      .o_rd_Ram      (o_rd_Ram),
      .o_busy        (o_busy),
      .o_halted      (o_halted),
      .o_illegal     (o_illegal),
      .o_cycle_count (o_cycle_count)
   );

   // {selA, selB, wr_Acc, op, wr_Ram, rd_Ram}
   function automatic logic [7:0] exp_strobes(input logic [4:0] opc);
      case (opc)
         5'h01:   return 8'b00_0_0_00_1_0;
         5'h02:   return 8'b00_0_1_00_0_1;
         5'h03:   return 8'b01_0_1_00_0_0;
         5'h04:   return 8'b10_0_1_00_0_1;
         5'h05:   return 8'b10_1_1_00_0_0;
         5'h06:   return 8'b10_0_1_01_0_1;
         5'h07:   return 8'b10_1_1_01_0_0;
         5'h08:   return 8'b10_0_1_10_0_1;
         5'h09:   return 8'b10_1_1_10_0_0;
         5'h0A:   return 8'b10_0_1_11_0_1;
         5'h0B:   return 8'b10_1_1_11_0_0;
         default: return 8'h00;
      endcase
   endfunction

   task automatic load(input int addr, input logic [4:0] opc, input logic [10:0] opnd);
      mem[addr] = {opc, opnd};
   endtask

   task automatic push(input logic [10:0] pc, input logic [4:0] opc, input logic [10:0] opnd);
      exp_t e;
      e.pc      = pc;
      e.operand = opnd;
      e.strb    = exp_strobes(opc);
      sb_q.push_back(e);
   endtask

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic run_until_halt(output int busy, output bit timeout);
      busy    = 0;
      timeout = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (o_busy) busy++;
         if (o_halted) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   // FETCH must be strobe-free; each EXEC consumes one scoreboard entry
   always @(negedge clk) begin : monitor
      logic [7:0] act;
      exp_t       e;
      act = {o_selA, o_selB, o_wr_Acc, o_op, o_wr_Ram, o_rd_Ram};
      if (rst || !o_busy) begin
         phase = 0;
      end else if (phase == 0) begin
         n_cmp++;
         if (act !== 8'h00) begin
            n_err++;
            $display("FAIL fetch_strobes pc=%h got %b expected 00000000", o_pc, act);
         end
         phase = 1;
      end else begin
         phase = 0;
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL exec_unexpected pc=%h strobes=%b expected no instruction", o_pc, act);
         end else begin
            e = sb_q.pop_front();
            if (act !== e.strb || o_pc !== e.pc || o_operand !== e.operand) begin
               n_err++;
               $display("FAIL exec_strobes got pc=%h opnd=%h strb=%b expected pc=%h opnd=%h strb=%b",
                        o_pc, o_operand, act, e.pc, e.operand, e.strb);
            end
         end
      end
   end

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({o_pc, o_busy, o_halted, o_illegal, o_wr_Acc, o_wr_Ram, o_rd_Ram, o_cycle_count} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got pc=%h busy=%b halted=%b illegal=%b cnt=%0d expected all 0",
                  o_pc, o_busy, o_halted, o_illegal, o_cycle_count);
      end
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (o_busy !== 1'b0 || o_pc !== 11'h0 || o_halted !== 1'b0) begin
         n_err++;
         $display("FAIL idle_hold got busy=%b pc=%h halted=%b expected 0 0 0", o_busy, o_pc, o_halted);
      end
   endtask

   task automatic test_program();
      int busy;
      bit to;
      int exp_cnt;
      load(0, 5'h03, 11'd5);
      load(1, 5'h05, 11'd3);
      load(2, 5'h01, 11'd7);
      load(3, 5'h00, 11'd0);
      push(0, 5'h03, 11'd5);
      push(1, 5'h05, 11'd3);
      push(2, 5'h01, 11'd7);
      push(3, 5'h00, 11'd0);
      do_start();
      run_until_halt(busy, to);
`ifdef BIP_CYCLE_COUNT_EN
      exp_cnt = 8;
`else
      exp_cnt = 0;
`endif
      n_cmp++;
      if (to || busy !== 8) begin
         n_err++;
         $display("FAIL prog_busy got %0d timeout=%0d expected 8 timeout=0", busy, to);
      end
      n_cmp++;
      if (o_halted !== 1'b1 || o_pc !== 11'd3 || o_illegal !== 1'b0 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL prog_halt got halted=%b pc=%h illegal=%b busy=%b expected 1 003 0 0",
                  o_halted, o_pc, o_illegal, o_busy);
      end
      n_cmp++;
      if (o_cycle_count !== exp_cnt) begin
         n_err++;
         $display("FAIL prog_cycles got %0d expected %0d", o_cycle_count, exp_cnt);
      end
      n_cmp++;
      if (sb_q.size() !== 0) begin
         n_err++;
         $display("FAIL prog_drain got %0d pending expected 0", sb_q.size());
      end
   endtask

   task automatic test_logic_ops();
      int busy;
      bit to;
      logic [4:0]  opcs [9] = '{5'h08, 5'h09, 5'h0A, 5'h0B, 5'h02, 5'h06, 5'h07, 5'h04, 5'h00};
      logic [10:0] opnd [9] = '{11'd4, 11'h0F, 11'd9, 11'h55, 11'd6, 11'd2, 11'd1, 11'd3, 11'd0};
      for (int i = 0; i < 9; i++) begin
         load(i, opcs[i], opnd[i]);
         push(11'(i), opcs[i], opnd[i]);
      end
      do_start();
      run_until_halt(busy, to);
      n_cmp++;
      if (to || busy !== 18 || o_pc !== 11'd8 || o_illegal !== 1'b0) begin
         n_err++;
         $display("FAIL logic_run got busy=%0d pc=%h illegal=%b timeout=%0d expected 18 008 0 0",
                  busy, o_pc, o_illegal, to);
      end
   endtask

   task automatic test_jmp_wrap();
      load(0, 5'h0C, 11'h7FF);
      load(2047, 5'h03, 11'd1);
      push(11'h000, 5'h0C, 11'h7FF);
      push(11'h7FF, 5'h03, 11'd1);
      do_start();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (o_pc !== 11'h7FF) begin
         n_err++;
         $display("FAIL jmp_target got pc=%h expected 7ff", o_pc);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (o_pc !== 11'h000 || o_busy !== 1'b1) begin
         n_err++;
         $display("FAIL pc_wrap got pc=%h busy=%b expected 000 1", o_pc, o_busy);
      end
      do_reset();
      n_cmp++;
      if (sb_q.size() !== 0) begin
         n_err++;
         $display("FAIL jmp_drain got %0d pending expected 0", sb_q.size());
      end
   endtask

   task automatic test_branch();
      int busy;
      bit to;
      acc_zero = 1'b1;
      load(0, 5'h0D, 11'd20);
      load(20, 5'h0E, 11'd20);
      load(21, 5'h00, 11'd0);
      load(1, 5'h0E, 11'd30);
      load(30, 5'h00, 11'd0);
      push(11'd0, 5'h0D, 11'd20);
      push(11'd20, 5'h0E, 11'd20);
      push(11'd21, 5'h00, 11'd0);
      do_start();
      run_until_halt(busy, to);
      n_cmp++;
      if (to || busy !== 6 || o_pc !== 11'd21) begin
         n_err++;
         $display("FAIL branch_zero got pc=%h busy=%0d timeout=%0d expected 015 6 0", o_pc, busy, to);
      end
      acc_zero = 1'b0;
      push(11'd0, 5'h0D, 11'd20);
      push(11'd1, 5'h0E, 11'd30);
      push(11'd30, 5'h00, 11'd0);
      do_start();
      run_until_halt(busy, to);
      n_cmp++;
      if (to || busy !== 6 || o_pc !== 11'd30) begin
         n_err++;
         $display("FAIL branch_nonzero got pc=%h busy=%0d timeout=%0d expected 01e 6 0", o_pc, busy, to);
      end
   endtask

   task automatic test_illegal();
      int busy;
      bit to;
      load(0, 5'h03, 11'd1);
      load(1, 5'h1F, 11'h155);
      push(11'd0, 5'h03, 11'd1);
      push(11'd1, 5'h1F, 11'h155);
      do_start();
      run_until_halt(busy, to);
      n_cmp++;
      if (to || o_illegal !== 1'b1 || o_halted !== 1'b1 || o_pc !== 11'd1 || busy !== 4) begin
         n_err++;
         $display("FAIL illegal_halt got illegal=%b halted=%b pc=%h busy=%0d expected 1 1 001 4",
                  o_illegal, o_halted, o_pc, busy);
      end
      push(11'd0, 5'h03, 11'd1);
      push(11'd1, 5'h1F, 11'h155);
      do_start();
      n_cmp++;
      if (o_illegal !== 1'b0 || o_pc !== 11'd0 || o_busy !== 1'b1 || o_halted !== 1'b0) begin
         n_err++;
         $display("FAIL illegal_restart got illegal=%b pc=%h busy=%b halted=%b expected 0 000 1 0",
                  o_illegal, o_pc, o_busy, o_halted);
      end
      run_until_halt(busy, to);
      n_cmp++;
      if (to || o_illegal !== 1'b1) begin
         n_err++;
         $display("FAIL illegal_again got illegal=%b timeout=%0d expected 1 0", o_illegal, to);
      end
   endtask

   task automatic test_reset_mid();
      load(0, 5'h01, 11'd9);
      load(1, 5'h00, 11'd0);
      push(11'd0, 5'h01, 11'd9);
      do_start();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (o_wr_Ram !== 1'b1) begin
         n_err++;
         $display("FAIL sto_write got wr_Ram=%b expected 1", o_wr_Ram);
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({o_pc, o_busy, o_halted, o_illegal, o_selA, o_selB, o_wr_Acc, o_op, o_wr_Ram, o_rd_Ram,
           o_cycle_count} !== '0) begin
         n_err++;
         $display("FAIL reset_abort got pc=%h busy=%b wr_Ram=%b halted=%b cnt=%0d expected all 0",
                  o_pc, o_busy, o_wr_Ram, o_halted, o_cycle_count);
      end
      @(posedge clk); #1 rst = 1'b0;
      n_cmp++;
      if (sb_q.size() !== 0) begin
         n_err++;
         $display("FAIL reset_drain got %0d pending expected 0", sb_q.size());
      end
   endtask

   task automatic test_start_ignored();
      int busy;
      bit halted_seen;
      load(0, 5'h03, 11'd5);
      load(1, 5'h05, 11'd3);
      load(2, 5'h01, 11'd7);
      load(3, 5'h00, 11'd0);
      push(0, 5'h03, 11'd5);
      push(1, 5'h05, 11'd3);
      push(2, 5'h01, 11'd7);
      push(3, 5'h00, 11'd0);
      do_start();
      start       = 1'b1;
      busy        = 0;
      halted_seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (c == 5) start = 1'b0;
         if (o_busy) busy++;
         if (o_halted) begin
            halted_seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (!halted_seen || busy !== 8 || o_pc !== 11'd3 || sb_q.size() !== 0) begin
         n_err++;
         $display("FAIL start_ignored got halted=%b busy=%0d pc=%h pending=%0d expected 1 8 003 0",
                  halted_seen, busy, o_pc, sb_q.size());
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      acc_zero = 1'b0;
      for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
      test_reset();
      test_program();
      test_logic_ops();
      test_jmp_wrap();
      test_branch();
      test_illegal();
      test_reset_mid();
      test_start_ignored();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish expected finish before 200us");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
